// File: rtl/gpio_pkg.sv
// Shared definitions for the APB GPIO controller: register offsets,
// APB phase states and the direction encoding.
package gpio_pkg;

    localparam logic [4:0] GPIO_DATA_OUT   = 5'h00;
    localparam logic [4:0] GPIO_DIR        = 5'h04;
    localparam logic [4:0] GPIO_SET        = 5'h08;
    localparam logic [4:0] GPIO_CLR        = 5'h0C;
    localparam logic [4:0] GPIO_DATA_IN    = 5'h10;
    localparam logic [4:0] GPIO_RISE_EN    = 5'h14;
    localparam logic [4:0] GPIO_FALL_EN    = 5'h18;
    localparam logic [4:0] GPIO_IRQ_STATUS = 5'h1C;

    // DIR bit value that makes a pin drive its pad
    localparam logic DIR_OUT = 1'b1;

    typedef enum logic {
        IDLE  = 1'b0,
        SETUP = 1'b1
    } apb_state_e;

endpackage

// File: rtl/gpio_apb_ctrl_sync_edge.sv
// Pad-input synchroniser chain plus a previous-value register that
// produces per-pin rising and falling edge pulses.
module gpio_sync_edge #(
    parameter int N_PINS      = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [N_PINS-1:0] pin_in,
    output logic [N_PINS-1:0] sync_o,
    output logic [N_PINS-1:0] rise_o,
    output logic [N_PINS-1:0] fall_o
);

    logic [SYNC_STAGES-1:0][N_PINS-1:0] sync_q, sync_d;
    logic [N_PINS-1:0]                  prev_q, prev_d;

    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], pin_in};
        prev_d = sync_q[SYNC_STAGES-1];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '0;
            prev_q <= '0;
        end else begin
            sync_q <= sync_d;
            prev_q <= prev_d;
        end
    end

    assign sync_o = sync_q[SYNC_STAGES-1];
    assign rise_o = sync_o & ~prev_q;
    assign fall_o = ~sync_o & prev_q;

endmodule

// File: rtl/gpio_apb_ctrl.sv
// APB slave GPIO controller: direction, data-out with atomic set/clear,
// synchronised input readback and per-pin edge interrupts (W1C status).
module gpio_apb_ctrl
    import gpio_pkg::*;
#(
    parameter int N_PINS      = 16,
    parameter int DW          = 16,
    parameter int AW          = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic              PCLK,
    input  logic              PRESETn,
    input  logic              PSEL,
    input  logic              PENABLE,
    input  logic              PWRITE,
    input  logic [AW-1:0]     PADDR,
    input  logic [DW-1:0]     PWDATA,
    output logic [DW-1:0]     PRDATA,
    output logic              PREADY,
    output logic              PSLVERR,
    input  logic [N_PINS-1:0] gpio_in,
    output logic [N_PINS-1:0] gpio_out,
    output logic [N_PINS-1:0] gpio_oe,
    output logic              irq
);

    apb_state_e        state_q, state_d;
    logic [N_PINS-1:0] data_out_q, data_out_d;
    logic [N_PINS-1:0] dir_q, dir_d;
    logic [N_PINS-1:0] rise_en_q, rise_en_d;
    logic [N_PINS-1:0] fall_en_q, fall_en_d;
    logic [N_PINS-1:0] irq_status_q, irq_status_d;
    logic [DW-1:0]     prdata_q, prdata_d;

    logic [N_PINS-1:0] sync_s, rise_s, fall_s;
    logic [N_PINS-1:0] wdata_s, rdata_s, dir_mask_s;
    logic [4:0]        addr_s;
    logic              addr_err_s, err_s, valid_s, wr_s, rd_setup_s;

    gpio_sync_edge #(
        .N_PINS      (N_PINS),
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync_edge (
        .clk    (PCLK),
        .rst    (PRESETn),
        .pin_in (gpio_in),
        .sync_o (sync_s),
        .rise_o (rise_s),
        .fall_o (fall_s)
    );

    always_comb begin
        state_d = IDLE;
        if (PSEL && !PENABLE) begin
            state_d = SETUP;
        end else begin
            state_d = IDLE;
        end
    end

    // A write to the read-only input register is flagged like a bad address
    always_comb begin
        addr_s     = PADDR[4:0];
        addr_err_s = (PADDR[1:0] != 2'b00) || (PADDR[AW-1:5] != '0);
        err_s      = addr_err_s || (PWRITE && (addr_s == GPIO_DATA_IN));
        valid_s    = PSEL && PENABLE && (state_q == SETUP);
        wr_s       = valid_s && PWRITE && !err_s;
        rd_setup_s = PSEL && !PENABLE && !PWRITE;
        wdata_s    = PWDATA[N_PINS-1:0];
        dir_mask_s = DIR_OUT ? dir_q : ~dir_q;
    end

    assign PREADY  = PSEL & PENABLE;
    assign PSLVERR = valid_s & err_s;

    always_comb begin
        rdata_s = '0;
        case (addr_s)
            GPIO_DATA_OUT:   rdata_s = data_out_q;
            GPIO_DIR:        rdata_s = dir_q;
            GPIO_DATA_IN:    rdata_s = sync_s;
            GPIO_RISE_EN:    rdata_s = rise_en_q;
            GPIO_FALL_EN:    rdata_s = fall_en_q;
            GPIO_IRQ_STATUS: rdata_s = irq_status_q;
            default:         rdata_s = '0;
        endcase
        prdata_d = prdata_q;
        if (rd_setup_s) begin
            prdata_d = err_s ? '0 : DW'(rdata_s);
        end else begin
            prdata_d = prdata_q;
        end
    end

    // Edge events are OR-ed in after the W1C so a coincident edge survives
    always_comb begin
        data_out_d   = data_out_q;
        dir_d        = dir_q;
        rise_en_d    = rise_en_q;
        fall_en_d    = fall_en_q;
        irq_status_d = irq_status_q;
        if (wr_s) begin
            case (addr_s)
                GPIO_DATA_OUT:   data_out_d   = wdata_s;
                GPIO_DIR:        dir_d        = wdata_s;
                GPIO_SET:        data_out_d   = data_out_q | (wdata_s & dir_mask_s);
                GPIO_CLR:        data_out_d   = data_out_q & ~(wdata_s & dir_mask_s);
                GPIO_RISE_EN:    rise_en_d    = wdata_s;
                GPIO_FALL_EN:    fall_en_d    = wdata_s;
                GPIO_IRQ_STATUS: irq_status_d = irq_status_q & ~wdata_s;
                default:         data_out_d   = data_out_q;
            endcase
        end else begin
            data_out_d = data_out_q;
        end
        irq_status_d = irq_status_d | (rise_s & rise_en_q) | (fall_s & fall_en_q);
    end

    always_ff @(posedge PCLK) begin
        if (PRESETn) begin
            state_q      <= IDLE;
            data_out_q   <= '0;
            dir_q        <= '0;
            rise_en_q    <= '0;
            fall_en_q    <= '0;
            irq_status_q <= '0;
            prdata_q     <= '0;
        end else begin
            state_q      <= state_d;
            data_out_q   <= data_out_d;
            dir_q        <= dir_d;
            rise_en_q    <= rise_en_d;
            fall_en_q    <= fall_en_d;
            irq_status_q <= irq_status_d;
            prdata_q     <= prdata_d;
        end
    end

    assign PRDATA   = prdata_q;
    assign gpio_out = data_out_q;
    assign gpio_oe  = dir_q;
    assign irq      = |irq_status_q;

endmodule

// File: tb/tb_gpio_apb_ctrl.sv
// Scoreboard bench for gpio_apb_ctrl: APB responses are queued at issue time
// and checked by a monitor; pin outputs are checked directly.
module tb_gpio_apb_ctrl;

    logic        PCLK = 1'b0;
    logic        PRESETn, PSEL, PENABLE, PWRITE;
    logic [7:0]  PADDR;
    logic [15:0] PWDATA, PRDATA;
    logic        PREADY, PSLVERR;
    logic [15:0] gpio_in, gpio_out, gpio_oe;
    logic        irq;

    logic        p8_sel, p8_en, p8_wr, p8_ready, p8_slverr, irq8;
    logic [7:0]  p8_addr, g8_in, g8_out, g8_oe;
    logic [31:0] p8_wdata, p8_rdata, rd8;

    typedef struct packed {
        logic        chk_rd;
        logic [15:0] rdata;
        logic        slverr;
        logic [7:0]  addr;
    } exp_t;

    exp_t sb_q[$];
    int   checks   = 0;
    int   failures = 0;

    gpio_apb_ctrl dut (
        .PCLK(PCLK), .PRESETn(PRESETn), .PSEL(PSEL), .PENABLE(PENABLE),
        .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA(PRDATA),
        .PREADY(PREADY), .PSLVERR(PSLVERR), .gpio_in(gpio_in),
        .gpio_out(gpio_out), .gpio_oe(gpio_oe), .irq(irq)
    );

    gpio_apb_ctrl #(.N_PINS(8), .DW(32), .AW(8), .SYNC_STAGES(2)) dut8 (
        .PCLK(PCLK), .PRESETn(PRESETn), .PSEL(p8_sel), .PENABLE(p8_en),
        .PWRITE(p8_wr), .PADDR(p8_addr), .PWDATA(p8_wdata), .PRDATA(p8_rdata),
        .PREADY(p8_ready), .PSLVERR(p8_slverr), .gpio_in(g8_in),
        .gpio_out(g8_out), .gpio_oe(g8_oe), .irq(irq8)
    );

    always #5 PCLK = ~PCLK;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", nm, act, exp);
        end
    endtask

    always @(negedge PCLK) begin : monitor
        exp_t e;
        if (PSEL && PENABLE && PREADY) begin
            if (sb_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL apb_unexpected addr=%h", PADDR);
            end else begin
                e = sb_q.pop_front();
                chk($sformatf("slverr@%h", e.addr), {31'd0, PSLVERR}, {31'd0, e.slverr});
                if (e.chk_rd) begin
                    chk($sformatf("rdata@%h", e.addr), {16'd0, PRDATA}, {16'd0, e.rdata});
                end
            end
        end
    end

    task automatic push_exp(input logic rd, input logic [7:0] a, input logic [15:0] exp_rd,
                            input logic exp_err);
        exp_t e;
        e.chk_rd = rd;
        e.rdata  = exp_rd;
        e.slverr = exp_err;
        e.addr   = a;
        sb_q.push_back(e);
    endtask

    task automatic apb_xfer(input logic wr, input logic [7:0] a, input logic [15:0] d,
                            input logic [15:0] exp_rd, input logic exp_err);
        push_exp(!wr, a, exp_rd, exp_err);
        @(posedge PCLK) #1;
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = wr; PADDR = a; PWDATA = d;
        @(posedge PCLK) #1;
        PENABLE = 1'b1;
        @(posedge PCLK) #1;
        PSEL = 1'b0; PENABLE = 1'b0;
    endtask

    task automatic apb_wr(input logic [7:0] a, input logic [15:0] d);
        apb_xfer(1'b1, a, d, 16'h0000, 1'b0);
    endtask

    task automatic apb_rd(input logic [7:0] a, input logic [15:0] exp_rd);
        apb_xfer(1'b0, a, 16'h0000, exp_rd, 1'b0);
    endtask

    task automatic p8_xfer(input logic wr, input logic [7:0] a, input logic [31:0] d,
                           output logic [31:0] rd);
        @(posedge PCLK) #1;
        p8_sel = 1'b1; p8_en = 1'b0; p8_wr = wr; p8_addr = a; p8_wdata = d;
        @(posedge PCLK) #1;
        p8_en = 1'b1;
        rd = p8_rdata;
        chk("p8_slverr", {31'd0, p8_slverr}, 32'd0);
        @(posedge PCLK) #1;
        p8_sel = 1'b0; p8_en = 1'b0;
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge PCLK) #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        PRESETn = 1'b1; PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
        PADDR = 8'h00; PWDATA = 16'h0000; gpio_in = 16'h0000;
        p8_sel = 1'b0; p8_en = 1'b0; p8_wr = 1'b0; p8_addr = 8'h00;
        p8_wdata = 32'h0; g8_in = 8'h00;
        wait_cyc(3);
        PRESETn = 1'b0;
        chk("rst_gpio_out", {16'd0, gpio_out}, 32'h0);
        chk("rst_irq", {31'd0, irq}, 32'h0);

        // Populate state, then reset in the middle of a write
        apb_wr(8'h00, 16'h1234);
        apb_wr(8'h04, 16'h00FF);
        chk("pre_rst_out", {16'd0, gpio_out}, 32'h1234);
        apb_rd(8'h00, 16'h1234);
        push_exp(1'b0, 8'h00, 16'h0000, 1'b0);
        @(posedge PCLK) #1;
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 8'h00; PWDATA = 16'hABCD;
        @(posedge PCLK) #1;
        PENABLE = 1'b1; PRESETn = 1'b1;
        @(posedge PCLK) #1;
        PSEL = 1'b0; PENABLE = 1'b0;
        @(posedge PCLK) #1;
        PRESETn = 1'b0;
        chk("midrst_out", {16'd0, gpio_out}, 32'h0);
        chk("midrst_oe", {16'd0, gpio_oe}, 32'h0);
        chk("midrst_prdata", {16'd0, PRDATA}, 32'h0);
        chk("midrst_irq", {31'd0, irq}, 32'h0);
        apb_rd(8'h00, 16'h0000);

        // Set / clear masked by DIR
        apb_wr(8'h04, 16'h00FF);
        apb_wr(8'h08, 16'hFFFF);
        chk("set_out", {16'd0, gpio_out}, 32'h00FF);
        apb_wr(8'h0C, 16'h000F);
        chk("clr_out", {16'd0, gpio_out}, 32'h00F0);
        chk("clr_oe", {16'd0, gpio_oe}, 32'h00FF);
        apb_rd(8'h08, 16'h0000);
        apb_rd(8'h0C, 16'h0000);
        apb_rd(8'h04, 16'h00FF);

        // Input synchroniser latency
        gpio_in = 16'h0005;
        apb_rd(8'h10, 16'h0000);
        apb_rd(8'h10, 16'h0005);
        gpio_in = 16'h0000;
        wait_cyc(5);

        // Edge interrupts
        apb_wr(8'h14, 16'h0001);
        apb_wr(8'h18, 16'h0002);
        gpio_in = 16'h0002;
        wait_cyc(5);
        chk("no_irq_unenabled", {31'd0, irq}, 32'h0);
        gpio_in = 16'h0003;
        wait_cyc(2);
        chk("irq_cyc2", {31'd0, irq}, 32'h0);
        wait_cyc(1);
        chk("irq_cyc3", {31'd0, irq}, 32'h1);
        apb_rd(8'h1C, 16'h0001);
        gpio_in = 16'h0001;
        wait_cyc(4);
        apb_rd(8'h1C, 16'h0003);
        apb_wr(8'h1C, 16'h0001);
        apb_rd(8'h1C, 16'h0002);
        gpio_in = 16'h0000;
        wait_cyc(4);
        apb_rd(8'h1C, 16'h0002);
        gpio_in = 16'h0001;
        apb_wr(8'h1C, 16'h0001);
        apb_rd(8'h1C, 16'h0003);
        apb_rd(8'h14, 16'h0001);
        apb_rd(8'h18, 16'h0002);

        // Error responses
        apb_xfer(1'b0, 8'h20, 16'h0000, 16'h0000, 1'b1);
        apb_xfer(1'b0, 8'h03, 16'h0000, 16'h0000, 1'b1);
        apb_xfer(1'b1, 8'h02, 16'hFFFF, 16'h0000, 1'b1);
        apb_xfer(1'b1, 8'h10, 16'hFFFF, 16'h0000, 1'b1);
        chk("err_no_write", {16'd0, gpio_out}, 32'h00F0);
        apb_rd(8'h00, 16'h00F0);

        // PENABLE with no setup phase
        push_exp(1'b0, 8'h04, 16'h0000, 1'b0);
        @(posedge PCLK) #1;
        PSEL = 1'b1; PENABLE = 1'b1; PWRITE = 1'b1; PADDR = 8'h04; PWDATA = 16'hFFFF;
        @(posedge PCLK) #1;
        PSEL = 1'b0; PENABLE = 1'b0;
        chk("nosetup_oe", {16'd0, gpio_oe}, 32'h00FF);
        apb_rd(8'h04, 16'h00FF);

        apb_wr(8'h1C, 16'h0003);
        chk("w1c_all_irq", {31'd0, irq}, 32'h0);

        // 8-pin / 32-bit instance
        p8_xfer(1'b1, 8'h00, 32'hFFFFFFFF, rd8);
        chk("p8_gpio_out", {24'd0, g8_out}, 32'h000000FF);
        p8_xfer(1'b0, 8'h00, 32'h0, rd8);
        chk("p8_readback", rd8, 32'h000000FF);

        wait_cyc(2);
        chk("sb_drained", sb_q.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/gpio_apb_ctrl.md
Name: gpio_apb_ctrl

Overview:
Parametrised APB-slave GPIO controller, the successor to the fixed 16-pin GPIO block. It provides pin direction, data-out, atomic set/clear, synchronised input readback, and per-pin rising/falling edge interrupts with a W1C status register. It exposes split in/out/oe buses to an external pad ring, so the block itself has no inout ports. It sits on the peripheral APB bus beside the other IRP peripherals.

Parameters:
N_PINS, 16, number of GPIO pins (1..DW).
DW, 16, APB data width.
AW, 8, APB address width.
SYNC_STAGES, 2, input synchroniser depth (>=2).

Ports:
PCLK  in  1  clock, all logic rising-edge.
PRESETn  in  1  reset; synchronous, active-high (name kept from codebase; PRESETn=1 resets).
PSEL  in  1  APB select.
PENABLE  in  1  APB enable.
PWRITE  in  1  1=write, 0=read.
PADDR  in  AW  byte address.
PWDATA  in  DW  write data.
PRDATA  out  DW  read data, registered.
PREADY  out  1  transfer ready.
PSLVERR  out  1  transfer error.
gpio_in  in  N_PINS  pad input (asynchronous).
gpio_out  out  N_PINS  pad output value (=DATA_OUT).
gpio_oe  out  N_PINS  pad output enable (=DIR, 1=drive).
irq  out  1  OR of IRQ_STATUS.

Behaviour:
- Reset (PRESETn=1 at a PCLK edge): all registers, sync chain, prev-input, PRDATA, irq and the phase FSM go to 0/IDLE. Reset mid-transfer aborts the transfer with no register write.
- Phase FSM has two states, IDLE and SETUP.
  - IDLE->SETUP when PSEL&!PENABLE.
  - SETUP->SETUP when PSEL&!PENABLE again.
  - Otherwise the next state is IDLE.
  - A valid access is a cycle with PSEL&PENABLE&(state==SETUP).
- PREADY=PSEL&PENABLE (zero wait states, so the bus never hangs). PENABLE asserted without a preceding setup phase is ignored: no write, PSLVERR=0.
- Register map (word-aligned; bits above N_PINS read 0 and ignore writes):
  - 0x00 DATA_OUT, RW.
  - 0x04 DIR, RW.
  - 0x08 SET, WO, reads 0. DATA_OUT |= wdata&DIR.
  - 0x0C CLR, WO, reads 0. DATA_OUT &= ~(wdata&DIR).
  - 0x10 DATA_IN, RO, synchronised pins regardless of DIR.
  - 0x14 RISE_EN, RW.
  - 0x18 FALL_EN, RW.
  - 0x1C IRQ_STATUS, RW1C.
- Writes commit at the PCLK edge ending the valid access cycle. The new value is visible on gpio_out/gpio_oe the next cycle.
- Reads: PRDATA is loaded at the edge ending the setup cycle (PSEL&!PENABLE&!PWRITE) and holds otherwise. It is zero-extended to DW.
- Errors:
  - PSLVERR=1 during a valid access when the address is unmapped (>0x1C), PADDR[1:0]!=0, or the access is a write to DATA_IN.
  - An erroring access writes nothing, and its read returns 0.
- Input path: gpio_in passes through a SYNC_STAGES flop chain, then a prev register.
  - rise = sync&~prev; fall = ~sync&prev.
  - DATA_IN shows a pin change SYNC_STAGES cycles after it is sampled.
  - IRQ_STATUS bit sets one cycle after that.
- IRQ_STATUS[i] sets on (rise[i]&RISE_EN[i])|(fall[i]&FALL_EN[i]). A W1C write clears bits. If an edge and a W1C hit the same bit in the same cycle, the set wins.
- irq=|IRQ_STATUS (combinational from the register).
- After reset the sync/prev registers are 0, so a pin held high produces a rise event. No status bit sets because RISE_EN=0.
- Because SET and CLR are distinct addresses, the two never conflict within one access.

Decomposition:
- Shared package gpio_pkg holds the register offset constants (GPIO_DATA_OUT..GPIO_IRQ_STATUS), the phase-state enum {IDLE,SETUP}, and the DIR encoding constant.
- Sub-module gpio_sync_edge (parameters N_PINS, SYNC_STAGES) contains the synchroniser, prev register and rise/fall outputs.
- The top level contains the APB FSM, decode, registers and irq.

Test Plan:
- Reset: hold PRESETn=1 for 2 cycles mid-write to 0x00 -> gpio_out=0, gpio_oe=0, irq=0, PRDATA=0; then read 0x00 -> 0x0000.
- Set/clear: write DIR=0x00FF, then SET 0xFFFF -> gpio_out=0x00FF; CLR 0x000F -> gpio_out=0x00F0; gpio_oe=0x00FF throughout.
- Input sync: gpio_in 0x0000->0x0005; read 0x10 one cycle later -> 0x0000; read at >=SYNC_STAGES+1 cycles -> 0x0005.
- Edge irq: RISE_EN=0x0001, FALL_EN=0x0002; raise gpio_in[0] -> IRQ_STATUS=0x0001 and irq=1 at cycle 3; drop gpio_in[1] -> 0x0003; W1C 0x0001 -> 0x0002; edge on pin 0 coincident with W1C 0x0001 -> bit 0 stays 1.
- Errors: read 0x20 -> PSLVERR=1, PRDATA=0; write 0x02 -> PSLVERR=1 and no register changes; PENABLE without setup -> no write.
- Parameters N_PINS=8, DW=32: write 0xFFFFFFFF to 0x00 -> readback 0x000000FF, gpio_out=0xFF.
